fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//   Instruction fetch stage directly upstream of ICache. Generates the PC and drives ICache read_request/addr.
//   Buffers returned words with their PCs in a small queue and hands them to decode over a valid/ready handshake.
//   Handles redirects (branch/jump/trap) by flushing the queue and discarding any in-flight response.
// PARAMETERS
//   RESET_VECTOR  32'h0000_0000  PC fetched first after reset
//   QUEUE_DEPTH   4              instruction queue entries; power of two, >=2
// PORTS
//   clk                  in   1   clock, all logic on posedge
//   reset                in   1   synchronous, active-low: reset==0 at posedge resets the block
//   cache_read_request   out  1   to ICache read_request; held high until response
//   cache_addr           out  32  to ICache addr; stable while request high
//   cache_read_response  in   1   ICache read_response; 1-cycle pulse, data valid same cycle
//   cache_read_data      in   32  ICache read_data
//   redirect_valid       in   1   1-cycle pulse: restart fetch at redirect_pc
//   redirect_pc          in   32  new PC; bits[1:0] forced to 0
//   instr_valid          out  1   queue head valid
//   instr_ready          in   1   decode accepts head when valid&&ready
//   instr_data           out  32  head instruction
//   instr_pc             out  32  head PC
// BEHAVIOUR
//   Reset: cache_read_request=0, cache_addr=RESET_VECTOR, instr_valid=0, queue empty, state IDLE, next_pc=RESET_VECTOR.
//   FSM states IDLE, REQ, DROP:
//     IDLE: if queue count<QUEUE_DEPTH -> REQ, request=1, cache_addr=next_pc (first request cycle after reset release).
//     REQ:  on response -> push {next_pc, data}; next_pc+=4; if post-push count<QUEUE_DEPTH stay REQ with new addr
//           the following cycle, else -> IDLE (request=0). Response cycle N -> instr_valid visible cycle N+1.
//     DROP: request stays high with the stale addr (ICache cannot cancel); on response discard data, -> IDLE.
//   Only one request outstanding ever; a push can never hit a full queue.
//   Pop when instr_valid&&instr_ready; push and pop in the same cycle keep count unchanged.
//   Redirect (highest priority, overrides push and pop that cycle):
//     queue flushed (instr_valid=0 next cycle), next_pc=redirect_pc&~3.
//     REQ without response this cycle -> DROP. REQ with response this cycle -> data discarded, -> IDLE.
//     IDLE or DROP -> IDLE or DROP respectively (DROP still owes one discard); new PC fetched afterwards.
//   next_pc wraps 32'hFFFF_FFFC -> 32'h0. Reset mid-operation: all state cleared, in-flight response ignored.
// CONFIGURATION
//   FETCH_PERF_COUNTERS_EN defined: adds outputs perf_fetched[31:0] (words pushed), perf_dropped[31:0]
//   (responses discarded), perf_full_cycles[31:0] (cycles queue full); reset to 0, saturate at all-ones.
//   Undefined: ports and counters absent; fetch behaviour identical.
// STRUCTURE
//   fetch_pkg: fetch_state_t enum {IDLE,REQ,DROP}; fetch_entry_t struct {pc[31:0], instr[31:0]}; INSTR_BYTES=4.
//   Sub-module fetch_queue: synchronous FIFO of fetch_entry_t, push/pop/flush, count, registered head.
// TESTING (bench: ICache 1024B + Memory with utils/test_cache.hex)
//   Reset low 5 cycles then high -> first posedge after: request=1, cache_addr=0x0; queue empty.
//   instr_ready=1 -> instr_pc sequence 0x0,0x4,0x8,0xC with instr_data matching hex words 0..3.
//   instr_ready=0, QUEUE_DEPTH=4 -> exactly 4 pushes (PCs 0x0..0xC), request drops to 0; ready=1 resumes at 0x10.
//   Redirect to 0x46 while REQ at 0x8 pending -> 0x8 data never appears, next cache_addr=0x44, instr_pc=0x44.
//   Redirect coinciding with response -> response dropped, queue empty next cycle, fetch restarts at redirect_pc.
//   Reset asserted while in DROP -> outputs return to reset values; first fetch after release at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
// Optional feature macro used by fetch_unit: FETCH_PERF_COUNTERS_EN.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Instructions are word aligned; the two low PC bits are always zero.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries.
// Flush empties the queue and overrides push/pop in the same cycle.
// The head entry and its valid flag come straight from registers.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [PTR_W:0] count_o,
    output logic         head_valid_o,
    output fetch_entry_t head_o
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !flush_i && (count_q != FULL_COUNT);
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (do_push && !do_pop) begin
            count_d = count_q + (PTR_W + 1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (PTR_W + 1)'(1);
        end
    end

    // Storage write; entries need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    // Pointer and occupancy update; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != '0);
    assign head_o       = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: generates PCs, issues one ICache read at a time,
// queues returned words with their PCs and hands them to decode.
// Handshake: decode takes the head entry on a cycle where instr_valid && instr_ready;
// a redirect in that cycle wins and the entry is flushed instead.
// Optional: define FETCH_PERF_COUNTERS_EN to add saturating perf counter outputs.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          QUEUE_DEPTH  = 4
) (
    input  logic         clk,
    input  logic         reset,
    output logic         cache_read_request,
    output logic [31:0]  cache_addr,
    input  logic         cache_read_response,
    input  logic [31:0]  cache_read_data,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [31:0]  instr_data,
    output logic [31:0]  instr_pc,
    output fetch_state_t dbg_state
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_dropped,
    output logic [31:0]  perf_full_cycles
`endif
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    fetch_state_t state_q;
    logic         req_q;
    logic [31:0]  addr_q;
    logic [31:0]  next_pc_q;
    logic [31:0]  pc_inc;

    logic [CW-1:0] q_count;
    logic [CW-1:0] count_after;
    logic          q_head_valid;
    fetch_entry_t  q_head;
    fetch_entry_t  push_entry;
    logic          push;
    logic          pop;

    // A response is only kept when no redirect arrives in the same cycle.
    assign push       = (state_q == REQ) && cache_read_response && !redirect_valid;
    assign pop        = q_head_valid && instr_ready && !redirect_valid;
    assign pc_inc     = next_pc_q + 32'(INSTR_BYTES);
    assign push_entry = '{pc: next_pc_q, instr: cache_read_data};

    // Occupancy the queue will have after this cycle's push and pop.
    always_comb begin
        count_after = q_count;
        if (push && !pop) begin
            count_after = q_count + CW'(1);
        end else if (!push && pop) begin
            count_after = q_count - CW'(1);
        end
    end

    // Fetch FSM: one outstanding read, DROP absorbs the response of a cancelled read.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            addr_q    <= RESET_VECTOR;
            next_pc_q <= RESET_VECTOR;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redirect_valid) begin
                        next_pc_q <= align_pc(redirect_pc);
                    end else if (q_count < DEPTH_C) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        addr_q  <= next_pc_q;
                    end
                end
                REQ: begin
                    if (redirect_valid) begin
                        next_pc_q <= align_pc(redirect_pc);
                        if (cache_read_response) begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                        end else begin
                            state_q <= DROP;
                        end
                    end else if (cache_read_response) begin
                        next_pc_q <= pc_inc;
                        if (count_after < DEPTH_C) begin
                            addr_q <= pc_inc;
                        end else begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (redirect_valid) begin
                        next_pc_q <= align_pc(redirect_pc);
                    end
                    if (cache_read_response) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .count_o      (q_count),
        .head_valid_o (q_head_valid),
        .head_o       (q_head)
    );

    assign cache_read_request = req_q;
    assign cache_addr         = addr_q;
    assign instr_valid        = q_head_valid;
    assign instr_data         = q_head.instr;
    assign instr_pc           = q_head.pc;
    assign dbg_state          = state_q;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetched_q;
    logic [31:0] dropped_q;
    logic [31:0] full_q;
    logic        drop_evt;

    assign drop_evt = cache_read_response &&
                      ((state_q == DROP) || ((state_q == REQ) && redirect_valid));

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetched_q <= '0;
            dropped_q <= '0;
            full_q    <= '0;
        end else begin
            if (push && (fetched_q != '1))                    fetched_q <= fetched_q + 32'd1;
            if (drop_evt && (dropped_q != '1))                dropped_q <= dropped_q + 32'd1;
            if ((q_count == DEPTH_C) && (full_q != '1))       full_q    <= full_q + 32'd1;
        end
    end

    assign perf_fetched     = fetched_q;
    assign perf_dropped     = dropped_q;
    assign perf_full_cycles = full_q;
`endif

endmodule
